// File: rtl/ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle controller.
// Contents: FSM state enum, opcodes, ALU/WB select codes, control word.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] WB_DMEM = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic       we;
    logic       asel;
    logic       bsel;
    logic       brun;
    logic [1:0] wbsel;
    logic [2:0] f3;
    logic [3:0] alu_sel;
    logic       branch;
    logic       jump;
    logic       mem;
    logic       store;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    we: 1'b0, asel: 1'b0, bsel: 1'b0,
    brun: 1'b0, wbsel: WB_ALU, f3: 3'd0,
    alu_sel: ALU_ADD, branch: 1'b0,
    jump: 1'b0, mem: 1'b0, store: 1'b0
  };

  function automatic logic br_taken(
    input logic [2:0] f3,
    input logic       eq,
    input logic       lt
  );
    case (f3)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return lt;
      3'b111:  return !lt;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I decoder: opcode/funct3/funct7 -> control word.
// Ports: opcode, funct3, funct7 in; ctrl word and illegal flag out.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl,
  output logic       illegal
);

  function automatic logic [3:0] alu_of(
    input logic [2:0] f3,
    input logic       alt,
    input logic       sub_ok
  );
    case (f3)
      3'd0:    return (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic f7_ok;
  assign f7_ok = (funct7 == 7'h00) || (funct7 == 7'h20);

  always_comb begin
    ctrl      = CTRL_IDLE;
    ctrl.bsel = 1'b1;
    illegal   = 1'b0;
    unique case (1'b1)
      (opcode == OP_LUI): begin
        ctrl.we      = 1'b1;
        ctrl.alu_sel = ALU_PASSB;
      end
      (opcode == OP_AUIPC): begin
        ctrl.we   = 1'b1;
        ctrl.asel = 1'b1;
      end
      (opcode == OP_JAL): begin
        ctrl.we    = 1'b1;
        ctrl.asel  = 1'b1;
        ctrl.wbsel = WB_PC4;
        ctrl.jump  = 1'b1;
      end
      (opcode == OP_JALR): begin
        ctrl.we    = 1'b1;
        ctrl.wbsel = WB_PC4;
        ctrl.jump  = 1'b1;
      end
      (opcode == OP_BRANCH): begin
        ctrl.asel   = 1'b1;
        ctrl.branch = 1'b1;
        ctrl.f3     = funct3;
        ctrl.brun   = funct3[1];
      end
      (opcode == OP_LOAD): begin
        ctrl.we    = 1'b1;
        ctrl.wbsel = WB_DMEM;
        ctrl.f3    = funct3;
        ctrl.mem   = 1'b1;
      end
      (opcode == OP_STORE): begin
        ctrl.f3    = funct3;
        ctrl.mem   = 1'b1;
        ctrl.store = 1'b1;
      end
      (opcode == OP_IMM): begin
        ctrl.we      = 1'b1;
        ctrl.alu_sel = alu_of(funct3, funct7[5], 1'b0);
      end
      (opcode == OP_REG): begin
        ctrl.we      = f7_ok;
        ctrl.bsel    = 1'b0;
        ctrl.alu_sel = alu_of(funct3, funct7[5], 1'b1);
        illegal      = !f7_ok;
      end
      (opcode == OP_FENCE),
      (opcode == OP_SYSTEM): ;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I sequencer: owns PC/IR, memory handshakes, datapath selects.
// Ports: clk/rst, imem/dmem handshakes, pc/ir, branch flags, select lines,
// illegal; with CTRL_PERF_CNT_EN also cycle_cnt and instret_cnt.
module riscv_mc_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic        dmem_req,
  input  logic        dmem_ready,
  output logic        dmem_we,
  output logic [31:0] pc,
  output logic [31:0] ir,
  input  logic [31:0] pc_next,
  input  logic        breq,
  input  logic        brlt,
  output logic        we_r,
  output logic        asel,
  output logic        bsel,
  output logic        brun,
  output logic        pcsel,
  output logic [1:0]  wbsel,
  output logic [2:0]  pl_c,
  output logic [3:0]  alu_sel,
  output logic        illegal
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, ir_q;
  ctrl_t       cw_q, dec_cw;
  logic        dec_ill;
  logic        taken_q, ill_q, br_now;

  ctrl_decode u_dec (
    .opcode  (ir_q[6:0]),
    .funct3  (ir_q[14:12]),
    .funct7  (ir_q[31:25]),
    .ctrl    (dec_cw),
    .illegal (dec_ill)
  );

  assign br_now = cw_q.branch &
                  br_taken(cw_q.f3, breq, brlt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= NOP;
      cw_q    <= CTRL_IDLE;
      taken_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && imem_ready)
        ir_q <= imem_rdata;
      if (state_q == S_DECODE) begin
        cw_q  <= dec_cw;
        ill_q <= ill_q | dec_ill;
      end
      // Flags are only valid in EXEC; hold the outcome to WB.
      if (state_q == S_EXEC)
        taken_q <= br_now;
      if (state_q == S_WB)
        pc_q <= pc_next;
    end
  end

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    we_r     = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    brun     = 1'b0;
    pcsel    = 1'b0;
    wbsel    = WB_ALU;
    pl_c     = 3'd0;
    alu_sel  = ALU_ADD;
    if (state_q == S_EXEC || state_q == S_MEM ||
        state_q == S_WB) begin
      asel    = cw_q.asel;
      bsel    = cw_q.bsel;
      brun    = cw_q.brun;
      wbsel   = cw_q.wbsel;
      pl_c    = cw_q.mem ? cw_q.f3 : 3'd0;
      alu_sel = cw_q.alu_sel;
      pcsel   = cw_q.jump | taken_q;
    end
    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = dec_ill ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        pcsel   = cw_q.jump | br_now;
        state_d = cw_q.mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cw_q.store;
        if (dmem_ready) state_d = S_WB;
      end
      S_WB: begin
        we_r    = cw_q.we;
        state_d = S_FETCH;
      end
      S_TRAP: ;
      default: state_d = S_FETCH;
    endcase
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign illegal = ill_q;

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (state_q == S_WB)
        instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/riscv_mc_ctrl.md
Name: riscv_mc_ctrl

Overview:
Multi-cycle sequencer for the RV32I datapath (reg file, ALU, A/B muxes, extend, DMEM, branch_comp). Owns the PC and instruction registers, handshakes with instruction and data memory, and drives every datapath select/enable line per state. Sits beside the datapath at core level, replacing hard-wired single-cycle decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
imem_ready  in  1  IR word valid this cycle
imem_rdata  in  32  fetched instruction
imem_req  out  1  fetch request
dmem_req  out  1  data access request
dmem_ready  in  1  data access complete this cycle
dmem_we  out  1  store (1) / load (0), valid with dmem_req
pc  out  32  current PC register
ir  out  32  latched instruction, feeds datapath ins
pc_next  in  32  datapath next-PC (pc+4 or alu_out per pcsel)
breq  in  1  branch_comp equal
brlt  in  1  branch_comp less-than
we_r  out  1  reg-file write enable
asel  out  1  1 = PC into ALU A
bsel  out  1  1 = imm into ALU B
brun  out  1  1 = unsigned compare
pcsel  out  1  1 = next PC from ALU
wbsel  out  2  00 DMEM, 01 ALU, 10 PC+4
pl_c  out  3  load/store size = funct3
alu_sel  out  4  ALU op code
illegal  out  1  sticky illegal-instruction flag

Behaviour:
- Reset (rst=1 at edge): state=FETCH, pc=RESET_PC, ir=32'h0000_0013 (NOP), illegal=0; all request/enable outputs 0; wbsel=01, alu_sel=ADD, other selects 0. Applies in any state, including mid-handshake; requests drop the following cycle.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: imem_req=1 until imem_ready; on imem_ready ir<=imem_rdata, ->DECODE. No timeout.
- DECODE: register control word from ir (opcode/funct3/funct7); unknown opcode, or funct7 not in {0x00,0x20} for R-type -> TRAP. Else ->EXEC.
- EXEC: control word on outputs; branch taken latched: BEQ breq, BNE !breq, BLT/BLTU brlt, BGE/BGEU !brlt; brun=1 for BLTU/BGEU. Load/store ->MEM, else ->WB.
- MEM: dmem_req=1, dmem_we=1 for store; address/data come from datapath. Hold until dmem_ready, then ->WB. Load data captured by datapath in same cycle.
- WB: we_r=1 one cycle for R/I-ALU/LUI/AUIPC/load/JAL/JALR (never if rd=x0 is irrelevant: reg file ignores x0). pc<=pc_next; ->FETCH.
- pcsel=1 in EXEC..WB for JAL, JALR, taken branch; else 0.
- Selects constant from EXEC through WB; in FETCH/DECODE all enables 0.
- alu_sel: 0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASSB (LUI). Loads/stores/branches/JAL/JALR/AUIPC use ADD. SUB/SRA from funct7=0x20 (SUB only R-type).
- asel=1 for AUIPC, JAL, branches; bsel=1 for all except R-type.
- wbsel: loads 00, JAL/JALR 10, others 01.
- TRAP: illegal=1, no requests, pc frozen; exit only via rst.
- Latency: ALU/branch/jump 4 cycles + fetch wait; load/store 5 cycles + fetch and data waits.
- FENCE/ECALL/EBREAK treated as NOP (no write, pc+4).

Optional Feature:
CTRL_PERF_CNT_EN: adds outputs cycle_cnt[31:0] (increments every non-reset cycle) and instret_cnt[31:0] (increments in WB exit); both cleared by rst, wrap at 2^32. Without macro: ports and counters absent.

Decomposition:
- Package ctrl_pkg: state enum, opcode localparams, ALU_* codes, WB_* codes, NOP constant.
- Sub-module ctrl_decode: combinational ir -> control word + illegal; FSM registers its output in DECODE.

Test Plan:
- Reset then imem_ready=1 always, ADDI x1,x0,5 -> imem_req in cycle 0, WB at cycle 3 with we_r=1, bsel=1, wbsel=01, alu_sel=0; pc=4 after.
- BEQ with breq=1, pc_next=0x40 -> pcsel=1 EXEC/WB, pc=0x40; repeat breq=0 -> pcsel=0.
- LW, dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, pl_c=010, wbsel=00, we_r only in WB.
- SW -> dmem_we=1, we_r=0 throughout.
- ir=32'hFFFF_FFFF -> TRAP, illegal=1, pc frozen 10 cycles; rst -> pc=RESET_PC, illegal=0.
- rst asserted during MEM with dmem_ready=0 -> next cycle dmem_req=0, state FETCH, pc=RESET_PC.
